// File: rtl/crc_emr_pkg.sv
// -----------------------------------------------------------------------------
// crc_emr_pkg
// Shared types and constants for the CRC error-message-register sequencer:
//   - state_t     : sequencer states
//   - EMR field positions (bit 0 is the first bit shifted out of the atom)
//   - err_type_t  : decoded values of the EMR error-type field
//   - helpers that pull individual fields out of a captured EMR
// No ports (package).
// -----------------------------------------------------------------------------
package crc_emr_pkg;

  localparam int EMR_WIDTH_DEFAULT = 68;
  localparam int CNT_WIDTH_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ALIGN = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  // EMR field layout
  localparam int SYNDROME_LSB   = 0;
  localparam int SYNDROME_W     = 32;
  localparam int FRAME_ADDR_LSB = 32;
  localparam int FRAME_ADDR_W   = 16;
  localparam int DW_LOC_LSB     = 48;
  localparam int DW_LOC_W       = 10;
  localparam int BIT_LOC_LSB    = 58;
  localparam int BIT_LOC_W      = 5;
  localparam int ERR_TYPE_LSB   = 63;
  localparam int ERR_TYPE_W     = 4;
  localparam int RSVD_LSB       = 67;
  localparam int RSVD_W         = 1;

  typedef enum logic [ERR_TYPE_W-1:0] {
    ERR_NONE          = 4'h0,
    ERR_SINGLE_BIT    = 4'h1,
    ERR_DOUBLE_ADJ    = 4'h2,
    ERR_UNCORRECTABLE = 4'hF
  } err_type_t;

  function automatic logic [ERR_TYPE_W-1:0] emr_err_type(
    input logic [EMR_WIDTH_DEFAULT-1:0] emr_val
  );
    return emr_val[ERR_TYPE_LSB +: ERR_TYPE_W];
  endfunction

  function automatic logic [FRAME_ADDR_W-1:0] emr_frame_addr(
    input logic [EMR_WIDTH_DEFAULT-1:0] emr_val
  );
    return emr_val[FRAME_ADDR_LSB +: FRAME_ADDR_W];
  endfunction

endpackage

// File: rtl/crc_emr_sequencer_if.sv
// -----------------------------------------------------------------------------
// crc_emr_sequencer_if
// Bundles the atom-facing and status-facing signals of the sequencer.
//   crc_error_in    : raw crcerror from the atom (asynchronous)
//   crc_regout      : atom regout[0], serial EMR data
//   crc_shiftnld    : to atom shiftnld (0 = load, 1 = shift)
//   crc_error_event : one-cycle pulse per synchronized rising edge of crc_error_in
//   emr / emr_valid : last captured EMR and its one-cycle update strobe
//   busy            : sequencer not idle
//   err_count       : saturating count of completed captures
//   overrun         : sticky, error edge seen while busy
//   overrun_clr     : synchronous clear of overrun
// Modports: master = sequencer side, slave = atom/status side.
// -----------------------------------------------------------------------------
interface crc_emr_sequencer_if
  import crc_emr_pkg::*;
#(
  parameter int EMR_WIDTH = EMR_WIDTH_DEFAULT,
  parameter int CNT_WIDTH = CNT_WIDTH_DEFAULT
);
  logic                 crc_error_in;
  logic                 crc_regout;
  logic                 crc_shiftnld;
  logic                 crc_error_event;
  logic [EMR_WIDTH-1:0] emr;
  logic                 emr_valid;
  logic                 busy;
  logic [CNT_WIDTH-1:0] err_count;
  logic                 overrun;
  logic                 overrun_clr;

  modport master (
    input  crc_error_in, crc_regout, overrun_clr,
    output crc_shiftnld, crc_error_event, emr, emr_valid, busy, err_count, overrun
  );

  modport slave (
    output crc_error_in, crc_regout, overrun_clr,
    input  crc_shiftnld, crc_error_event, emr, emr_valid, busy, err_count, overrun
  );
endinterface

// File: rtl/crc_emr_sequencer_sync_edge.sv
// -----------------------------------------------------------------------------
// vi_sync_edge
// Multi-flop synchronizer followed by a rising-edge detector, for any slow
// asynchronous status level entering the clk domain.
//   clk      : destination clock
//   rst      : asynchronous active-high reset (clears every flop)
//   async_in : asynchronous level input
//   rise     : one-cycle pulse when the synchronized level goes 0 -> 1
// -----------------------------------------------------------------------------
module vi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);
  logic [STAGES-1:0] sync_reg;
  logic              edge_d_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg   <= '0;
      edge_d_reg <= 1'b0;
    end else begin
      sync_reg[0] <= async_in;
      for (int i = 1; i < STAGES; i++) begin
        sync_reg[i] <= sync_reg[i-1];
      end
      edge_d_reg <= sync_reg[STAGES-1];
    end
  end

  assign rise = sync_reg[STAGES-1] & ~edge_d_reg;
endmodule

// File: rtl/crc_emr_sequencer.sv
// -----------------------------------------------------------------------------
// crc_emr_sequencer
// Reacts to each new CRC error from the Stratix V CRC atom: pulls shiftnld low
// to parallel-load the atom's EMR, waits for the first serial bit to appear,
// shifts EMR_WIDTH bits in LSB first, then publishes the result with a valid
// strobe and bumps a saturating error counter.
//   clk : free-running clock shared with the atom
//   rst : asynchronous active-high reset
//   bus : crc_emr_sequencer_if.master (atom handshake + status outputs)
// -----------------------------------------------------------------------------
module crc_emr_sequencer
  import crc_emr_pkg::*;
#(
  parameter int EMR_WIDTH     = EMR_WIDTH_DEFAULT,
  parameter int LOAD_CYCLES   = 3,
  parameter int SHIFT_LATENCY = 1,
  parameter int SYNC_STAGES   = 2,
  parameter int CNT_WIDTH     = CNT_WIDTH_DEFAULT
) (
  input logic                  clk,
  input logic                  rst,
  crc_emr_sequencer_if.master  bus
);
  localparam int BIT_W      = (EMR_WIDTH > 1) ? $clog2(EMR_WIDTH) : 1;
  localparam int PH_MAX     = (LOAD_CYCLES > SHIFT_LATENCY) ? LOAD_CYCLES : SHIFT_LATENCY;
  localparam int PH_W       = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int LOAD_LAST  = LOAD_CYCLES - 1;
  localparam int ALIGN_LAST = (SHIFT_LATENCY > 0) ? SHIFT_LATENCY - 1 : 0;
  localparam int BIT_LAST   = EMR_WIDTH - 1;
  // With zero latency the first EMR bit is already on regout after the load.
  localparam state_t AFTER_LOAD = (SHIFT_LATENCY > 0) ? ALIGN : SHIFT;

  state_t               state_reg, state_next;
  logic [PH_W-1:0]      phase_reg;
  logic [BIT_W-1:0]     bit_idx_reg;
  logic [EMR_WIDTH-1:0] shadow_reg;
  logic [EMR_WIDTH-1:0] emr_reg;
  logic [CNT_WIDTH-1:0] err_count_reg;
  logic                 overrun_reg;

  logic error_event;
  logic shiftnld;
  logic busy;
  logic emr_valid;

  vi_sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk      (clk),
    .rst      (rst),
    .async_in (bus.crc_error_in),
    .rise     (error_event)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic. Events outside IDLE never start a capture; they only
  // feed the overrun flag below.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (error_event) state_next = LOAD;
      LOAD:    if (phase_reg == PH_W'(LOAD_LAST)) state_next = AFTER_LOAD;
      ALIGN:   if (phase_reg == PH_W'(ALIGN_LAST)) state_next = SHIFT;
      SHIFT:   if (bit_idx_reg == BIT_W'(BIT_LAST)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    shiftnld  = 1'b1;
    busy      = 1'b1;
    emr_valid = 1'b0;
    case (state_reg)
      IDLE:    busy = 1'b0;
      LOAD:    shiftnld = 1'b0;
      DONE:    emr_valid = 1'b1;
      default: ;
    endcase
  end

  // Phase and bit counters. The phase counter restarts on every state change
  // so LOAD and ALIGN each count their own cycles from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_reg   <= '0;
      bit_idx_reg <= '0;
    end else begin
      if (state_next != state_reg) begin
        phase_reg <= '0;
      end else if (state_reg == LOAD || state_reg == ALIGN) begin
        phase_reg <= phase_reg + PH_W'(1);
      end

      if (state_reg == SHIFT && state_next == SHIFT) begin
        bit_idx_reg <= bit_idx_reg + BIT_W'(1);
      end else begin
        bit_idx_reg <= '0;
      end
    end
  end

  // Capture path, counter and overrun flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_reg    <= '0;
      emr_reg       <= '0;
      err_count_reg <= '0;
      overrun_reg   <= 1'b0;
    end else begin
      // New bits enter at the top, so after EMR_WIDTH shifts the first bit
      // received sits at bit 0.
      if (state_reg == SHIFT) begin
        shadow_reg <= {bus.crc_regout, shadow_reg[EMR_WIDTH-1:1]};
      end

      // emr only moves here, so a partial shadow is never exposed.
      if (state_reg == DONE) begin
        emr_reg <= shadow_reg;
        if (err_count_reg != {CNT_WIDTH{1'b1}}) begin
          err_count_reg <= err_count_reg + CNT_WIDTH'(1);
        end
      end

      // Setting takes priority over a simultaneous clear.
      if (error_event && busy) begin
        overrun_reg <= 1'b1;
      end else if (bus.overrun_clr) begin
        overrun_reg <= 1'b0;
      end
    end
  end

  assign bus.crc_shiftnld    = shiftnld;
  assign bus.crc_error_event = error_event;
  assign bus.emr             = emr_reg;
  assign bus.emr_valid       = emr_valid;
  assign bus.busy            = busy;
  assign bus.err_count       = err_count_reg;
  assign bus.overrun         = overrun_reg;
endmodule

// File: tb/tb_crc_emr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_crc_emr_sequencer
// Drives two sequencers (16-bit and 2-bit error counters) from one CRC atom
// model. A timeline model predicts every output each cycle from the event
// times: an accepted event at cycle T means shiftnld low T+1..T+3, busy
// T+1..T+73, emr_valid at T+73, emr/err_count updated from T+74.
// -----------------------------------------------------------------------------
module tb_crc_emr_sequencer;
  localparam int W     = 68;
  localparam int LOADC = 3;
  localparam int LAT   = 1;
  localparam int SYNC  = 2;
  localparam int TOTAL = LOADC + LAT + W + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic crc_error_in = 1'b0;
  logic overrun_clr = 1'b0;

  // Atom model: parallel load while shiftnld is low, shift right while high,
  // regout registered once more to give one cycle of shift latency.
  logic [W-1:0] atom_emr = '0;
  logic [W-1:0] atom_sr = '0;
  logic         atom_out = 1'b0;

  always #5 clk = ~clk;

  crc_emr_sequencer_if #(.EMR_WIDTH(W), .CNT_WIDTH(16)) bus1();
  crc_emr_sequencer_if #(.EMR_WIDTH(W), .CNT_WIDTH(2))  bus2();

  assign bus1.crc_error_in = crc_error_in;
  assign bus1.crc_regout   = atom_out;
  assign bus1.overrun_clr  = overrun_clr;
  assign bus2.crc_error_in = crc_error_in;
  assign bus2.crc_regout   = atom_out;
  assign bus2.overrun_clr  = overrun_clr;

  crc_emr_sequencer #(
    .EMR_WIDTH(W), .LOAD_CYCLES(LOADC), .SHIFT_LATENCY(LAT),
    .SYNC_STAGES(SYNC), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  crc_emr_sequencer #(
    .EMR_WIDTH(W), .LOAD_CYCLES(LOADC), .SHIFT_LATENCY(LAT),
    .SYNC_STAGES(SYNC), .CNT_WIDTH(2)
  ) dut_sat (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  always @(posedge clk) begin
    if (!bus1.crc_shiftnld) atom_sr <= atom_emr;
    else                    atom_sr <= atom_sr >> 1;
    atom_out <= atom_sr[0];
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Observed activity, used by the directed checks.
  int ev_cnt = 0, val_cnt1 = 0, val_cnt2 = 0, low_cnt = 0;
  int last_ev_cyc = 0, last_val_cyc = 0;

  // Model state
  logic [SYNC+1:0] hist = '0;
  bit              have_cap = 1'b0;
  int              start = 0;
  logic [W-1:0]    cap_val = '0;
  logic [W-1:0]    emr_exp = '0;
  int              n_caps = 0;
  logic            ov_exp = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d want %0d", name, cyc, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_emr();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[W-1:0];
  endfunction

  always @(negedge clk) begin
    logic ev, busy_e, shn_e, val_e;
    int   cnt1, cnt2;
    cyc++;
    if (bus1.crc_error_event) begin ev_cnt++; last_ev_cyc = cyc; end
    if (bus1.emr_valid) begin val_cnt1++; last_val_cyc = cyc; end
    if (bus2.emr_valid) val_cnt2++;
    if (!bus1.crc_shiftnld) low_cnt++;

    if (rst) begin
      hist = '0; have_cap = 1'b0; emr_exp = '0; n_caps = 0; ov_exp = 1'b0;
      ev = 1'b0; busy_e = 1'b0; shn_e = 1'b1; val_e = 1'b0;
    end else begin
      hist   = {hist[SYNC:0], crc_error_in};
      ev     = hist[SYNC] & ~hist[SYNC+1];
      busy_e = have_cap && cyc > start && cyc <= start + TOTAL;
      if (ev && !busy_e) begin
        have_cap = 1'b1;
        start    = cyc;
      end
      shn_e = !(have_cap && cyc > start && cyc <= start + LOADC);
      val_e = have_cap && cyc == start + TOTAL;
      if (have_cap && cyc == start + LOADC) cap_val = atom_emr;
    end

    cnt1 = (n_caps > 65535) ? 65535 : n_caps;
    cnt2 = (n_caps > 3) ? 3 : n_caps;

    chk("event",     W'(bus1.crc_error_event), W'(ev));
    chk("shiftnld",  W'(bus1.crc_shiftnld),    W'(shn_e));
    chk("busy",      W'(bus1.busy),            W'(busy_e));
    chk("emr_valid", W'(bus1.emr_valid),       W'(val_e));
    chk("emr",       bus1.emr,                 emr_exp);
    chk("err_count", W'(bus1.err_count),       W'(cnt1));
    chk("overrun",   W'(bus1.overrun),         W'(ov_exp));
    chk("sat_shiftnld",  W'(bus2.crc_shiftnld), W'(shn_e));
    chk("sat_emr_valid", W'(bus2.emr_valid),    W'(val_e));
    chk("sat_emr",       bus2.emr,              emr_exp);
    chk("sat_err_count", W'(bus2.err_count),    W'(cnt2));
    chk("sat_overrun",   W'(bus2.overrun),      W'(ov_exp));

    if (!rst) begin
      if (val_e) begin
        emr_exp = cap_val;
        n_caps++;
      end
      if (ev && busy_e)      ov_exp = 1'b1;
      else if (overrun_clr)  ov_exp = 1'b0;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    crc_error_in = 1'b0;
    overrun_clr  = 1'b0;
    step(3);
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    step(3);
  endtask

  task automatic raise(input int hi);
    crc_error_in = 1'b1;
    step(hi);
    crc_error_in = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int v0;
    int k;
    v0 = val_cnt1;
    k  = 0;
    while (val_cnt1 == v0 && k < budget) begin
      step(1);
      k++;
    end
    checks++;
    if (val_cnt1 == v0) begin
      errors++;
      $display("FAIL wait_valid cycle %0d: got no emr_valid within %0d cycles, want one", cyc, budget);
    end
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a, b;
    int l0, e0, v0, hi, lo;

    // Reset release, quiet inputs
    #1 rst = 1'b1;
    step(4);
    rst = 1'b0;
    l0 = low_cnt;
    step(200);
    chk_int("idle_low_cycles", low_cnt - l0, 0);
    chk("idle_err_count", W'(bus1.err_count), W'(0));

    // Single error with a known EMR
    atom_emr = 68'h0_1234_5678_9ABC_DEF0;
    l0 = low_cnt;
    e0 = ev_cnt;
    raise(5);
    wait_valid(200);
    chk_int("single_event_pulses", ev_cnt - e0, 1);
    chk_int("single_load_cycles", low_cnt - l0, 3);
    chk_int("single_valid_latency", last_val_cyc - last_ev_cyc, 73);
    chk("single_emr", bus1.emr, 68'h0_1234_5678_9ABC_DEF0);
    chk("single_err_count", W'(bus1.err_count), W'(1));

    // Level held high: one capture only
    do_reset();
    atom_emr = rand_emr();
    v0 = val_cnt1;
    crc_error_in = 1'b1;
    step(1000);
    crc_error_in = 1'b0;
    step(5);
    chk_int("held_captures", val_cnt1 - v0, 1);
    chk("held_err_count", W'(bus1.err_count), W'(1));
    chk("held_overrun", W'(bus1.overrun), W'(0));

    // Second edge 20 cycles into a capture
    do_reset();
    a = rand_emr();
    atom_emr = a;
    e0 = ev_cnt;
    raise(4);
    while (cyc < last_ev_cyc + 17) step(1);
    atom_emr = ~a;
    raise(3);
    wait_valid(200);
    chk_int("overrun_event_gap", last_ev_cyc - (last_val_cyc - 73), 20);
    chk_int("overrun_events", ev_cnt - e0, 2);
    chk("overrun_first_emr", bus1.emr, a);
    chk("overrun_flag", W'(bus1.overrun), W'(1));
    chk("overrun_err_count", W'(bus1.err_count), W'(1));

    // Clear and set in the same cycle: set wins
    step(5);
    atom_emr = rand_emr();
    raise(2);
    step(10);
    crc_error_in = 1'b1;
    step(2);
    overrun_clr = 1'b1;
    step(1);
    overrun_clr  = 1'b0;
    crc_error_in = 1'b0;
    chk("clr_vs_set_overrun", W'(bus1.overrun), W'(1));
    wait_valid(200);
    overrun_clr = 1'b1;
    step(1);
    overrun_clr = 1'b0;
    chk("clr_alone_overrun", W'(bus1.overrun), W'(0));

    // Reset in the middle of SHIFT
    step(5);
    atom_emr = rand_emr();
    raise(3);
    while (cyc < last_ev_cyc + 39) step(1);
    v0 = val_cnt1;
    rst = 1'b1;
    #1;
    chk("midrst_shiftnld", W'(bus1.crc_shiftnld), W'(1));
    chk("midrst_emr", bus1.emr, '0);
    chk("midrst_err_count", W'(bus1.err_count), W'(0));
    step(3);
    rst = 1'b0;
    step(80);
    chk_int("midrst_no_valid", val_cnt1 - v0, 0);
    b = rand_emr();
    atom_emr = b;
    raise(3);
    wait_valid(200);
    chk("midrst_recapture_emr", bus1.emr, b);
    chk("midrst_recapture_count", W'(bus1.err_count), W'(1));

    // Counter saturation on the 2-bit instance
    do_reset();
    v0 = val_cnt2;
    repeat (5) begin
      atom_emr = rand_emr();
      raise(2);
      wait_valid(200);
      step(2);
    end
    chk_int("sat_valid_pulses", val_cnt2 - v0, 5);
    chk("sat_count_2bit", W'(bus2.err_count), W'(3));
    chk("sat_count_16bit", W'(bus1.err_count), W'(5));

    // Random error pulses, gaps and overrun clears
    for (int ep = 0; ep < 150; ep++) begin
      atom_emr = rand_emr();
      hi = int'($urandom_range(1, 6));
      lo = int'($urandom_range(1, 110));
      crc_error_in = 1'b1;
      for (int i = 0; i < hi + lo; i++) begin
        if (i == hi) crc_error_in = 1'b0;
        overrun_clr = ($urandom_range(0, 15) == 0);
        step(1);
      end
    end
    crc_error_in = 1'b0;
    overrun_clr  = 1'b0;
    step(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/crc_emr_sequencer.md
Name: crc_emr_sequencer

Overview:
- Downstream consumer of the Stratix V CRC error-detection atom. Runs in the 100 MHz free-running clock domain that also clocks the atom.
- On each new CRC error it drives the atom's shiftnld to load the Error Message Register (EMR), then serially shifts the EMR out of regout[0].
- Presents the captured EMR in parallel with a valid pulse, and keeps an error count and an overrun flag for core status registers.

Parameters:
- EMR_WIDTH, 68, number of EMR bits shifted out and captured.
- LOAD_CYCLES, 3, cycles shiftnld is held low to parallel-load the EMR (atom minimum is 2).
- SHIFT_LATENCY, 1, cycles after shiftnld returns high before regout[0] carries EMR bit 0.
- SYNC_STAGES, 2, synchronizer depth on crc_error_in.
- CNT_WIDTH, 16, width of the saturating error counter.

Ports:
- clk  input  1  free-running clock; same clock that drives the atom clk.
- rst  input  1  asynchronous, active-high reset.
- crc_error_in  input  1  raw crcerror from the atom, asynchronous to clk.
- crc_regout  input  1  atom regout[0], serial EMR data.
- crc_shiftnld  output  1  to atom shiftnld; 0 = load, 1 = shift.
- crc_error_event  output  1  one-cycle pulse on each synchronized rising edge of crc_error_in.
- emr  output  EMR_WIDTH  last captured EMR, bit 0 = first bit shifted out.
- emr_valid  output  1  one-cycle pulse when emr updates.
- busy  output  1  high whenever the state is not IDLE.
- err_count  output  CNT_WIDTH  saturating count of completed captures.
- overrun  output  1  sticky; a new error edge occurred while busy.
- overrun_clr  input  1  synchronous clear of overrun.

Behaviour:
- Reset values: crc_shiftnld=1, emr=0, emr_valid=0, crc_error_event=0, busy=0, err_count=0, overrun=0, state=IDLE, all synchronizer flops=0.
- Synchronizer: crc_error_in passes through SYNC_STAGES flops, then one edge-detect flop. crc_error_event = sync & ~sync_d.
- Error edges: only rising edges start a capture. A level held high does not retrigger.
- IDLE: crc_shiftnld=1. On crc_error_event go to LOAD in the next cycle.
- LOAD: crc_shiftnld=0 for exactly LOAD_CYCLES cycles, then go to ALIGN.
- ALIGN: crc_shiftnld=1 for SHIFT_LATENCY cycles. If SHIFT_LATENCY=0, skip ALIGN and go straight to SHIFT.
- SHIFT: crc_shiftnld=1 for EMR_WIDTH cycles.
  - Each cycle, shift crc_regout into the shadow register so the first captured bit ends at bit 0 (LSB first).
  - The bit index counter is $clog2(EMR_WIDTH) bits wide and terminates at EMR_WIDTH-1; no wrap.
- DONE (1 cycle):
  - emr <= shadow; emr_valid=1.
  - err_count increments, saturating at all ones.
  - Return to IDLE.
- Latency for defaults: event in cycle T, LOAD T+1..T+3, ALIGN T+4, SHIFT T+5..T+72, emr_valid in T+73.
- busy=1 from T+1 through the DONE cycle.
- The shadow register is internal. emr changes only in DONE, so a partial capture is never visible.
- Overrun:
  - A crc_error_event while busy=1 sets overrun and is otherwise ignored; the capture in progress continues undisturbed.
  - If overrun_clr and a set condition occur in the same cycle, set wins.
- An event in the DONE cycle counts as busy: it sets overrun and is not started.
- Reset mid-operation: async return to IDLE, crc_shiftnld=1, emr and err_count cleared, no emr_valid pulse.

Decomposition:
- Package crc_emr_pkg holds:
  - State enum: IDLE, LOAD, ALIGN, SHIFT, DONE.
  - EMR field localparams: SYNDROME_LSB=0, SYNDROME_W=32, FRAME_ADDR_LSB=32, FRAME_ADDR_W=16, DW_LOC_LSB=48, DW_LOC_W=10, BIT_LOC_LSB=58, BIT_LOC_W=5, ERR_TYPE_LSB=63, ERR_TYPE_W=4, RSVD_LSB=67, RSVD_W=1.
  - Decoded ERR_TYPE codes.
- One sub-module: vi_sync_edge, the SYNC_STAGES synchronizer plus rising-edge detector. It is reusable for other asynchronous status inputs.
- The state machine, counters and shadow register stay in the top-level module.

Test Plan:
- Reset release, no error: all outputs at reset values for 200 cycles; crc_shiftnld stays 1.
- Single error, atom model serializing 68'h0_1234_5678_9ABC_DEF0 LSB first after load: crc_error_event 1 pulse; crc_shiftnld low for exactly 3 cycles; emr_valid exactly 73 cycles after the event; emr=68'h0_1234_5678_9ABC_DEF0; err_count=1.
- crc_error_in held high for 1000 cycles: exactly one capture, err_count=1, overrun=0.
- Second rising edge 20 cycles into a capture: first EMR correct, overrun=1, err_count=1. Then overrun_clr and a new edge in the same cycle: overrun stays 1.
- rst asserted in the middle of SHIFT (cycle T+40): crc_shiftnld=1 and emr=0 immediately; no emr_valid. A new error after release captures its full EMR correctly.
- Counter saturation with CNT_WIDTH forced to 2: 5 errors give err_count=3, with 5 emr_valid pulses.
